// File: rtl/tpu_job_scheduler.sv
// Round-robin scheduler that hands the systolic-array control unit to one job at a time.
// Optional WAIT-state watchdog abort is enabled by defining TPU_SCHED_WATCHDOG_EN.
module tpu_job_scheduler #(
  parameter int numRequesters  = 4,
  parameter int matrixSize     = 8,
  parameter int tileCountWidth = 8
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic [numRequesters-1:0]                       reqValid,
  input  logic [numRequesters-1:0][tileCountWidth-1:0]   reqTiles,
  output logic [numRequesters-1:0]                       reqReady,
  output logic                                           tpuStart,
  input  logic                                           tpuDone,
  output logic                                           busy,
  output logic [$clog2(numRequesters)-1:0]               grantId,
  output logic [tileCountWidth-1:0]                      tilesRemaining,
  output logic                                           jobDone,
  output logic [$clog2(numRequesters)-1:0]               jobDoneId
`ifdef TPU_SCHED_WATCHDOG_EN
  ,
  output logic                                           timeoutError,
  output logic                                           timeoutSticky
`endif
);

  localparam int idW = $clog2(numRequesters);

  if (numRequesters < 2 || matrixSize < 1) begin : g_param_check
    $error("tpu_job_scheduler: numRequesters must be >= 2 and matrixSize >= 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, COMPLETE} state_t;

  state_t                    stateReg, stateNext;
  logic [idW-1:0]            grantReg, grantNext;
  logic [idW-1:0]            rrPtrReg, rrPtrNext;
  logic [tileCountWidth-1:0] tilesReg, tilesNext;

  logic                      winnerFound;
  logic [idW-1:0]            winner;
  logic [idW:0]              searchSum;

`ifdef TPU_SCHED_WATCHDOG_EN
  localparam int wdLimit = 3 * matrixSize + 8;
  localparam int wdW     = $clog2(wdLimit + 1);

  logic [wdW-1:0] wdCountReg, wdCountNext;
  logic           abortReg, abortNext;
  logic           stickyReg, stickyNext;
`endif

  // Winner is the first pending requester at or after rrPtr, wrapping around.
  always_comb begin
    winnerFound = 1'b0;
    winner      = '0;
    searchSum   = '0;
    for (int i = 0; i < numRequesters; i++) begin
      searchSum = {1'b0, rrPtrReg} + (idW+1)'(i);
      if (searchSum >= (idW+1)'(numRequesters))
        searchSum = searchSum - (idW+1)'(numRequesters);
      if (!winnerFound && reqValid[searchSum[idW-1:0]]) begin
        winnerFound = 1'b1;
        winner      = searchSum[idW-1:0];
      end
    end
  end

  always_comb begin
    stateNext = stateReg;
    grantNext = grantReg;
    rrPtrNext = rrPtrReg;
    tilesNext = tilesReg;
    reqReady  = '0;
    tpuStart  = 1'b0;
    jobDone   = 1'b0;
    jobDoneId = '0;
`ifdef TPU_SCHED_WATCHDOG_EN
    wdCountNext = wdCountReg;
    abortNext   = abortReg;
    stickyNext  = stickyReg;
`endif
    unique case (stateReg)
      IDLE: begin
        if (winnerFound) begin
          // reqReady is combinational, so it is gated to stay low while reset is held.
          reqReady[winner] = reset;
          grantNext        = winner;
          tilesNext        = reqTiles[winner];
          stateNext        = (reqTiles[winner] == '0) ? COMPLETE : ISSUE;
        end
      end
      ISSUE: begin
        tpuStart  = 1'b1;
        stateNext = WAIT;
`ifdef TPU_SCHED_WATCHDOG_EN
        wdCountNext = '0;
`endif
      end
      WAIT: begin
        if (tpuDone) begin
          tilesNext = tilesReg - tileCountWidth'(1);
          stateNext = (tilesReg == tileCountWidth'(1)) ? COMPLETE : ISSUE;
        end
`ifdef TPU_SCHED_WATCHDOG_EN
        else if (wdCountReg == wdW'(wdLimit - 1)) begin
          stateNext  = COMPLETE;
          abortNext  = 1'b1;
          stickyNext = 1'b1;
        end else begin
          wdCountNext = wdCountReg + wdW'(1);
        end
`endif
      end
      COMPLETE: begin
        jobDone   = 1'b1;
        jobDoneId = grantReg;
        rrPtrNext = (grantReg == idW'(numRequesters - 1)) ? '0 : grantReg + idW'(1);
        stateNext = IDLE;
`ifdef TPU_SCHED_WATCHDOG_EN
        abortNext = 1'b0;
`endif
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateReg <= IDLE;
      grantReg <= '0;
      rrPtrReg <= '0;
      tilesReg <= '0;
`ifdef TPU_SCHED_WATCHDOG_EN
      wdCountReg <= '0;
      abortReg   <= 1'b0;
      stickyReg  <= 1'b0;
`endif
    end else begin
      stateReg <= stateNext;
      grantReg <= grantNext;
      rrPtrReg <= rrPtrNext;
      tilesReg <= tilesNext;
`ifdef TPU_SCHED_WATCHDOG_EN
      wdCountReg <= wdCountNext;
      abortReg   <= abortNext;
      stickyReg  <= stickyNext;
`endif
    end
  end

  assign busy           = (stateReg != IDLE);
  assign grantId        = grantReg;
  assign tilesRemaining = tilesReg;

`ifdef TPU_SCHED_WATCHDOG_EN
  assign timeoutError  = (stateReg == COMPLETE) && abortReg;
  assign timeoutSticky = stickyReg;
`endif

endmodule
